add4_rr_sched: RTL and testbench
================================

Name: add4_rr_sched

Overview:
- Shares one existing add4 datapath (four 4-bit operands -> 5-bit sum + ov carry bit) among NUM_REQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- The result of each granted request is registered into a single-entry output slot and tagged with the requester index.
- Sits between operand producers and a result consumer that can apply backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OP_W, 4, operand width; fixed to 4 to match the add4 datapath.
- ID_W, $clog2(NUM_REQ), width of the requester tag.
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ops  in  NUM_REQ*4*OP_W  per-requester operands; slice i = {d,c,b,a}, with a in the LSBs.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- resp_valid  out  1  result slot holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_sum  out  5  registered add4 sum.
- resp_ov  out  1  registered add4 ov; {resp_ov,resp_sum} = a+b+c+d, range 0..60.
- resp_id  out  ID_W  index of the requester that produced the result.
- txn_count  out  CNT_W  number of accepted requests; saturates at all-ones.

Behaviour:
- Reset (clk and rst, asynchronous, active-low):
  - resp_valid=0, resp_sum=0, resp_ov=0, resp_id=0, txn_count=0.
  - RR pointer=0, state=EMPTY.
  - Any pending result is discarded; no response is produced for it after reset.
- State machine, output slot:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on resp_ready with no accept in the same cycle.
  - FULL -> FULL on resp_ready with an accept in the same cycle (back-to-back).
  - FULL with resp_ready=0: hold all resp_* outputs stable.
- Slot free: slot_free = (state==EMPTY) | resp_ready. This is combinational and is the only resp_ready -> req_ready path.
- Grant:
  - Combinational pick of the first req_valid[i] scanning from index ptr upward, wrapping modulo NUM_REQ.
  - req_ready[i] = grant[i] & slot_free.
  - No request valid -> req_ready all zero.
- Accept: req_valid[g] & req_ready[g] on a clk rising edge.
  - Mux req_ops slice g into add4.
  - Register {ov,sum} and resp_id=g.
  - resp_valid=1 from the next cycle. Latency is 1 cycle from accept to resp_valid.
- Pointer update: on accept, ptr <= (g+1) mod NUM_REQ. With no accept, ptr is unchanged.
- Fairness: a requester holding valid continuously is granted within NUM_REQ accepts.
- Requester rules:
  - After raising valid, hold valid and ops stable until ready.
  - The block never depends on a request being withdrawn.
- Throughput: one result per cycle when resp_ready is held high.
- txn_count: increments on each accept; it holds at 2^CNT_W-1 instead of wrapping.
- Sampling: add4 is purely combinational; its output is sampled only at accept.
- Bounds: the muxed operand index is always < NUM_REQ, including non-power-of-2 counts.

Decomposition:
- Package add4_sched_pkg:
  - Constants OP_W=4, SUM_W=5.
  - Enum slot_state_t {EMPTY, FULL}.
  - Function rr_next(ptr, NUM_REQ).
- Sub-module rr_pick (NUM_REQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational.
- The existing add4 is instantiated once, unmodified.

Test Plan:
- Reset mid-transaction:
  - Stimulus: req0 ops {1,2,3,4} accepted, resp_ready=0; assert rst low.
  - Required response: resp_valid=0 immediately, txn_count=0; after release, no stale response appears.
- Single request:
  - Stimulus: req2 ops a=15,b=15,c=15,d=15.
  - Required response: req_ready[2] high the same cycle; next cycle resp_valid=1, {ov,sum}=60 (ov=1,sum=28), resp_id=2.
- Round-robin:
  - Stimulus: all four req_valid held high, resp_ready=1.
  - Required response: grant order 0,1,2,3,0; one accept per cycle; txn_count=5 after 5 cycles.
- Backpressure:
  - Stimulus: resp_ready=0 with slot FULL; req1 valid.
  - Required response: req_ready all zero; resp_* stable. Raise resp_ready and the same cycle shows req_ready[1]=1 (back-to-back); the next result has resp_id=1.
- Pointer wrap and skip:
  - Stimulus: ptr=3, only req1 valid.
  - Required response: grant 1; ptr becomes 2.
- Saturation:
  - Stimulus: txn_count preset by 65535 accepts (or forced), then 2 more accepts.
  - Required response: txn_count stays 0xFFFF.

Source files
------------

// File: rtl/add4_rr_sched_pkg.sv
// Shared constants, slot state encoding and round-robin helper for the
// add4 request scheduler.
package add4_sched_pkg;

   localparam int OP_W  = 4;
   localparam int SUM_W = 5;
   // Pointer arithmetic is done at this width so one helper covers 2..8 requesters.
   localparam int IDX_W = 3;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                                input int num_req);
      if (int'(ptr) + 1 >= num_req) return '0;
      return ptr + IDX_W'(1);
   endfunction

endpackage

// File: rtl/add4_rr_sched_if.sv
// Request/response bundle between operand producers, the scheduler and the
// result consumer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A producer holds valid and its data stable until that edge; ready
// may be asserted or withdrawn at any time and never waits on valid falling.
interface add4_rr_sched_if
   import add4_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*4*OP_W-1:0] req_ops;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [SUM_W-1:0]          resp_sum;
   logic                      resp_ov;
   logic [ID_W-1:0]           resp_id;
   logic [CNT_W-1:0]          txn_count;
   logic [0:0]                dbg_state;
   logic [ID_W-1:0]           dbg_ptr;

   modport master (
      output req_valid, req_ops, resp_ready,
      input  req_ready, resp_valid, resp_sum, resp_ov, resp_id, txn_count,
             dbg_state, dbg_ptr
   );

   modport slave (
      input  req_valid, req_ops, resp_ready,
      output req_ready, resp_valid, resp_sum, resp_ov, resp_id, txn_count,
             dbg_state, dbg_ptr
   );

endinterface

// File: rtl/add4.sv
// Existing four-operand 4-bit adder: {ov,sum} = a+b+c+d, purely combinational.
module add4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   input  logic [3:0] d,
   output logic [4:0] sum,
   output logic       ov
);

   logic [5:0] total;

   assign total     = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
   assign {ov, sum} = total;

endmodule

// File: rtl/add4_rr_sched_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      int base;
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      // An out-of-range pointer is treated as 0 so j always stays below NUM_REQ.
      base  = (int'(ptr) < NUM_REQ) ? int'(ptr) : 0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = base + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/add4_rr_sched.sv
// Shares one add4 among NUM_REQ requesters with round-robin arbitration and a
// single-entry tagged result slot that the consumer can stall.
module add4_rr_sched
   import add4_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   add4_rr_sched_if.slave       bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [0:0] S_EMPTY = EMPTY;
   localparam logic [0:0] S_FULL  = FULL;

   logic [0:0]         state;
   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    pick_idx;
   logic               pick_any;
   logic               slot_free;
   logic               accept;
   logic [4*OP_W-1:0]  sel_ops;
   logic [SUM_W-1:0]   add_sum;
   logic               add_ov;
   logic [SUM_W-1:0]   sum_q;
   logic               ov_q;
   logic [ID_W-1:0]    id_q;
   logic [CNT_W-1:0]   cnt_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // The only combinational resp_ready -> req_ready path: a draining slot is free.
   assign slot_free     = (state == S_EMPTY) | bus.resp_ready;
   assign bus.req_ready = grant & {NUM_REQ{slot_free}};
   assign accept        = pick_any & slot_free;

   // One-hot mux keeps the operand select in range for any NUM_REQ.
   always_comb begin
      sel_ops = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) sel_ops = bus.req_ops[i*4*OP_W +: 4*OP_W];
      end
   end

   add4 u_add4 (
      .a   (sel_ops[OP_W-1:0]),
      .b   (sel_ops[2*OP_W-1:OP_W]),
      .c   (sel_ops[3*OP_W-1:2*OP_W]),
      .d   (sel_ops[4*OP_W-1:3*OP_W]),
      .sum (add_sum),
      .ov  (add_ov)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_EMPTY;
         ptr   <= '0;
         sum_q <= '0;
         ov_q  <= 1'b0;
         id_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (accept) begin
            state <= S_FULL;
            sum_q <= add_sum;
            ov_q  <= add_ov;
            id_q  <= pick_idx;
            ptr   <= ID_W'(rr_next(IDX_W'(pick_idx), NUM_REQ));
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
         end else if (state == S_FULL && bus.resp_ready) begin
            state <= S_EMPTY;
         end
      end
   end

   assign bus.resp_valid = (state == S_FULL);
   assign bus.resp_sum   = sum_q;
   assign bus.resp_ov    = ov_q;
   assign bus.resp_id    = id_q;
   assign bus.txn_count  = cnt_q;
   assign bus.dbg_state  = state;
   assign bus.dbg_ptr    = ptr;

endmodule

// File: tb/tb_add4_rr_sched.sv
// Randomized and directed bench for add4_rr_sched against a queue-based
// reference model of the round-robin scheduler.
module tb_add4_rr_sched;

   localparam int N     = 4;
   localparam int CNT_W = 16;

   logic clk;
   logic rst;

   add4_rr_sched_if #(.NUM_REQ(N), .CNT_W(CNT_W)) bus ();

   add4_rr_sched #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int          n_checks;
   int          n_errors;
   logic [N-1:0] vld;
   logic [15:0] ops_v [N];
   logic [7:0]  exp_q [$];
   bit          m_full;
   int          m_ptr;
   int          m_cnt;
   int          last_acc;
   logic [N-1:0] seen_ready;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Winner is the valid requester with the smallest forward distance from ptr.
   function automatic int ref_pick(input logic [N-1:0] v, input int p);
      int best;
      int bestd;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            int d;
            d = (i - p + N) % N;
            if (d < bestd) begin
               best  = i;
               bestd = d;
            end
         end
      end
      return best;
   endfunction

   function automatic int ref_sum(input logic [15:0] o);
      return int'(o[3:0]) + int'(o[7:4]) + int'(o[11:8]) + int'(o[15:12]);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive();
      bus.req_valid = vld;
      for (int i = 0; i < N; i++) bus.req_ops[i*16 +: 16] = ops_v[i];
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      exp_q.delete();
   endtask

   // One clock: check everything at the negedge, then advance the model at the
   // posedge; returns at posedge+1 so the caller may change inputs.
   task automatic cycle();
      int g;
      bit fire;
      @(negedge clk);
      g = (!m_full || bus.resp_ready) ? ref_pick(vld, m_ptr) : -1;
      seen_ready = bus.req_ready;
      check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      check("resp_valid", 32'(bus.resp_valid), 32'(m_full));
      check("state", 32'(bus.dbg_state), 32'(m_full));
      if (m_full && exp_q.size() > 0)
         check("resp_data", 32'({bus.resp_id, bus.resp_ov, bus.resp_sum}), 32'(exp_q[0]));
      check("txn_count", 32'(bus.txn_count), 32'(m_cnt));
      check("ptr", 32'(bus.dbg_ptr), 32'(m_ptr));
      fire = m_full && bus.resp_ready;
      @(posedge clk);
      if (fire && exp_q.size() > 0) void'(exp_q.pop_front());
      if (g >= 0) begin
         exp_q.push_back({2'(g), 6'(ref_sum(ops_v[g]))});
         m_full = 1'b1;
         m_ptr  = (g + 1) % N;
         if (m_cnt < 65535) m_cnt++;
      end else if (fire) begin
         m_full = 1'b0;
      end
      last_acc = g;
      #1;
   endtask

   task automatic random_inputs();
      for (int i = 0; i < N; i++) begin
         if (last_acc == i) begin
            vld[i]   = ($urandom_range(0, 1) == 1);
            ops_v[i] = 16'($urandom);
         end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
            vld[i]   = 1'b1;
            ops_v[i] = 16'($urandom);
         end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      drive();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int rr_order [5];
      logic [7:0] held;
      rr_order = '{0, 1, 2, 3, 0};
      n_checks = 0;
      n_errors = 0;
      last_acc = -1;
      vld = '0;
      for (int i = 0; i < N; i++) ops_v[i] = '0;
      bus.resp_ready = 1'b0;
      drive();
      model_reset();
      rst = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_resp_bits", 32'({bus.resp_id, bus.resp_ov, bus.resp_sum}), 32'd0);
      check("rst_txn_count", 32'(bus.txn_count), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);
      check("rst_ptr", 32'(bus.dbg_ptr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // reset mid-transaction: result pending and stalled, then reset
      vld[0] = 1'b1;
      ops_v[0] = 16'h4321;
      bus.resp_ready = 1'b0;
      drive();
      cycle();
      vld = '0;
      drive();
      cycle();
      rst = 1'b0;
      #1;
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("midrst_txn_count", 32'(bus.txn_count), 32'd0);
      check("midrst_state", 32'(bus.dbg_state), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) cycle();

      // round-robin with all requesters busy
      vld = '1;
      for (int i = 0; i < N; i++) ops_v[i] = 16'($urandom);
      drive();
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("rr_order", 32'(seen_ready), 32'd1 << rr_order[k]);
      end
      check("rr_txn_count", 32'(bus.txn_count), 32'd5);

      // single request, maximum operands
      vld = 4'b0100;
      ops_v[2] = 16'hFFFF;
      drive();
      cycle();
      check("single_ready", 32'(seen_ready), 32'h4);
      vld = '0;
      drive();
      check("single_valid", 32'(bus.resp_valid), 32'd1);
      check("single_ov", 32'(bus.resp_ov), 32'd1);
      check("single_sum", 32'(bus.resp_sum), 32'd28);
      check("single_id", 32'(bus.resp_id), 32'd2);
      check("single_ptr", 32'(bus.dbg_ptr), 32'd3);

      // pointer at 3, only req1 valid: skip and wrap
      vld = 4'b0010;
      ops_v[1] = 16'h1234;
      drive();
      cycle();
      check("wrap_ready", 32'(seen_ready), 32'h2);
      check("wrap_ptr", 32'(bus.dbg_ptr), 32'd2);
      vld = '0;
      bus.resp_ready = 1'b0;
      drive();

      // backpressure with the slot full, then back-to-back release
      vld = 4'b0010;
      ops_v[1] = 16'h5A3C;
      drive();
      held = {bus.resp_id, bus.resp_ov, bus.resp_sum};
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("bp_ready", 32'(seen_ready), 32'd0);
         check("bp_stable", 32'({bus.resp_id, bus.resp_ov, bus.resp_sum}), 32'(held));
      end
      bus.resp_ready = 1'b1;
      drive();
      cycle();
      check("bp_release_ready", 32'(seen_ready), 32'h2);
      check("bp_next_id", 32'(bus.resp_id), 32'd1);
      check("bp_next_valid", 32'(bus.resp_valid), 32'd1);
      vld = '0;
      drive();

      // randomized traffic
      last_acc = -1;
      for (int k = 0; k < 3000; k++) begin
         random_inputs();
         cycle();
      end

      // saturation of the transaction counter
      vld = '1;
      bus.resp_ready = 1'b1;
      drive();
      while (m_cnt < 65535) begin
         if (last_acc >= 0) ops_v[last_acc] = 16'($urandom);
         drive();
         cycle();
      end
      for (int k = 0; k < 2; k++) cycle();
      check("sat_txn_count", 32'(bus.txn_count), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
